// File: rtl/bingo_ball_drawer_if.sv
// Ball presentation handshake between the drawer and its consumer.
// Carries the drawn ball in BCD and binary plus its fallback flag.
interface bingo_ball_drawer_if #(
  parameter int CNT_W = 7
) ();

  logic             valid;
  logic             ready;
  logic [7:0]       bcd;
  logic [CNT_W-1:0] bin;
  logic             fallback;

  modport master (
    output valid,
    output bcd,
    output bin,
    output fallback,
    input  ready
  );

  modport slave (
    input  valid,
    input  bcd,
    input  bin,
    input  fallback,
    output ready
  );

endinterface

// File: rtl/bingo_ball_drawer.sv
// Bingo ball drawer: filters BCD PRNG output into unique legal balls.
// Falls back to a linear bitmap scan after too many PRNG rejects.
module bingo_ball_drawer #(
  parameter int MAX_BALL  = 75,
  parameter int MAX_TRIES = 16,
  parameter int CNT_W     = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_new_game,
  input  logic             i_draw_req,
  input  logic [7:0]       i_prng_number,
  output logic             o_prng_step,
  bingo_ball_drawer_if.master ball,
  output logic [CNT_W-1:0] o_draw_count,
  output logic             o_all_drawn,
  output logic             o_busy
);

  localparam int TRY_W =
    (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam int MAP_N = 2 ** CNT_W;

  localparam logic [TRY_W-1:0] LP_TRY_LAST =
    TRY_W'(MAX_TRIES - 1);
  localparam logic [7:0] LP_MAX8 = 8'(MAX_BALL);
  localparam logic [CNT_W-1:0] LP_MAXC =
    CNT_W'(MAX_BALL);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_SCAN,
    ST_PRESENT,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [MAP_N-1:0]   r_bitmap;
  logic [CNT_W-1:0]   r_count;
  logic [TRY_W-1:0]   r_tries;
  logic [CNT_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_bin;
  logic [7:0]         r_bcd;
  logic               r_fallback;

  logic [3:0]         w_tens;
  logic [3:0]         w_units;
  logic               w_digits_ok;
  logic [7:0]         w_v;
  logic               w_in_range;
  logic [CNT_W-1:0]   w_idx;
  logic               w_accept;
  logic               w_last_try;
  logic               w_scan_free;
  logic               w_handshake;

  function automatic logic [7:0] f_bin2bcd(
    input logic [CNT_W-1:0] b
  );
    logic [31:0] t;
    logic [31:0] u;
    t = 32'(b) / 32'd10;
    u = 32'(b) % 32'd10;
    return {t[3:0], u[3:0]};
  endfunction

  assign w_tens      = i_prng_number[7:4];
  assign w_units     = i_prng_number[3:0];
  assign w_digits_ok = (w_tens <= 4'd9) &&
                       (w_units <= 4'd9);
  assign w_v = ({4'd0, w_tens} * 8'd10) +
               {4'd0, w_units};

  // Range check comes first so the bitmap is
  // only ever indexed by a legal ball number.
  assign w_in_range = w_digits_ok &&
                      (w_v != 8'd0) &&
                      (w_v <= LP_MAX8);
  assign w_idx = w_in_range ? CNT_W'(w_v) : '0;

  assign w_accept    = w_in_range && !r_bitmap[w_idx];
  assign w_last_try  = (r_tries == LP_TRY_LAST);
  assign w_scan_free = !r_bitmap[r_ptr];
  assign w_handshake = (r_state == ST_PRESENT) &&
                       ball.ready;

  assign o_prng_step  = (r_state == ST_SEARCH);
  assign o_all_drawn  = (r_state == ST_DONE);
  assign o_busy       = (r_state == ST_SEARCH) ||
                        (r_state == ST_SCAN) ||
                        (r_state == ST_PRESENT);
  assign o_draw_count = r_count;

  assign ball.valid    = (r_state == ST_PRESENT);
  assign ball.bcd      = r_bcd;
  assign ball.bin      = r_bin;
  assign ball.fallback = r_fallback;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; new_game aborts any draw.
  always_comb begin
    w_next = r_state;
    if (i_new_game) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_draw_req) w_next = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (w_accept) w_next = ST_PRESENT;
          else if (w_last_try) w_next = ST_SCAN;
        end
        ST_SCAN: begin
          if (w_scan_free) w_next = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (ball.ready) begin
            if (r_count == LP_MAXC) w_next = ST_DONE;
            else w_next = ST_IDLE;
          end
        end
        ST_DONE: w_next = ST_DONE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Drawn set, counters and the latched ball.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_new_game) begin
      r_bitmap   <= '0;
      r_count    <= '0;
      r_tries    <= '0;
      r_ptr      <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_fallback <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_draw_req) r_tries <= '0;
        end
        ST_SEARCH: begin
          if (w_accept) begin
            r_bin           <= w_idx;
            r_bcd           <= i_prng_number;
            r_bitmap[w_idx] <= 1'b1;
            r_count         <= r_count + 1'b1;
            r_fallback      <= 1'b0;
          end else begin
            r_tries <= r_tries + 1'b1;
            if (w_last_try) r_ptr <= CNT_W'(1);
          end
        end
        ST_SCAN: begin
          if (w_scan_free) begin
            r_bin           <= r_ptr;
            r_bcd           <= f_bin2bcd(r_ptr);
            r_bitmap[r_ptr] <= 1'b1;
            r_count         <= r_count + 1'b1;
            r_fallback      <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  logic w_unused;
  assign w_unused = w_handshake;

endmodule

// File: tb/tb_bingo_ball_drawer.sv
// Directed bench for bingo_ball_drawer.
// Instance A uses defaults; instance B is a 3-ball game.
module tb_bingo_ball_drawer;

  logic clk;
  logic rst;

  logic       a_new_game;
  logic       a_draw_req;
  logic [7:0] a_prng;
  logic       a_step;
  logic [6:0] a_count;
  logic       a_all;
  logic       a_busy;

  logic       b_new_game;
  logic       b_draw_req;
  logic [7:0] b_prng;
  logic       b_step;
  logic [6:0] b_count;
  logic       b_all;
  logic       b_busy;

  int checks;
  int failures;

  bingo_ball_drawer_if #(.CNT_W(7)) a_if ();
  bingo_ball_drawer_if #(.CNT_W(7)) b_if ();

  bingo_ball_drawer #(
    .MAX_BALL (75),
    .MAX_TRIES(16),
    .CNT_W    (7)
  ) u_a (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_new_game   (a_new_game),
    .i_draw_req   (a_draw_req),
    .i_prng_number(a_prng),
    .o_prng_step  (a_step),
    .ball         (a_if.master),
    .o_draw_count (a_count),
    .o_all_drawn  (a_all),
    .o_busy       (a_busy)
  );

  bingo_ball_drawer #(
    .MAX_BALL (3),
    .MAX_TRIES(4),
    .CNT_W    (7)
  ) u_b (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_new_game   (b_new_game),
    .i_draw_req   (b_draw_req),
    .i_prng_number(b_prng),
    .o_prng_step  (b_step),
    .ball         (b_if.master),
    .o_draw_count (b_count),
    .o_all_drawn  (b_all),
    .o_busy       (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({a_if.valid, a_step, a_count, a_all, a_busy}
        !== 11'd0) begin
      failures++;
      $display("FAIL reset_a: got v=%b s=%b c=%0d a=%b b=%b want 0",
               a_if.valid, a_step, a_count, a_all, a_busy);
    end
    checks++;
    if ({b_if.valid, b_step, b_count, b_all, b_busy}
        !== 11'd0) begin
      failures++;
      $display("FAIL reset_b: outputs not all zero");
    end
    checks++;
    if ({a_if.bcd, a_if.bin, a_if.fallback} !== 16'd0) begin
      failures++;
      $display("FAIL reset_ball: got bcd=%h bin=%0d fb=%b want 0",
               a_if.bcd, a_if.bin, a_if.fallback);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_draw;
    a_prng = 8'h42;
    a_draw_req = 1'b1;
    tick();
    a_draw_req = 1'b0;
    checks++;
    if (a_step !== 1'b1 || a_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL first_n1: got step=%b valid=%b want 1 0",
               a_step, a_if.valid);
    end
    tick();
    checks++;
    if (a_if.valid !== 1'b1 || a_if.bcd !== 8'h42 ||
        a_if.bin !== 7'd42 || a_if.fallback !== 1'b0) begin
      failures++;
      $display("FAIL first_n2: got v=%b bcd=%h bin=%0d fb=%b want 1 42 42 0",
               a_if.valid, a_if.bcd, a_if.bin, a_if.fallback);
    end
    a_if.ready = 1'b1;
    tick();
    a_if.ready = 1'b0;
    checks++;
    if (a_if.valid !== 1'b0 || a_count !== 7'd1 ||
        a_busy !== 1'b0) begin
      failures++;
      $display("FAIL first_hs: got v=%b cnt=%0d busy=%b want 0 1 0",
               a_if.valid, a_count, a_busy);
    end
  endtask

  task automatic test_rejects;
    logic [7:0] seq [4];
    seq[0] = 8'h42;
    seq[1] = 8'h00;
    seq[2] = 8'h80;
    seq[3] = 8'h07;
    a_prng = seq[0];
    a_draw_req = 1'b1;
    tick();
    a_draw_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_prng = seq[i];
      checks++;
      if (a_step !== 1'b1 || a_if.valid !== 1'b0) begin
        failures++;
        $display("FAIL rej_search%0d: got step=%b v=%b want 1 0",
                 i, a_step, a_if.valid);
      end
      tick();
    end
    checks++;
    if (a_if.valid !== 1'b1 || a_if.bcd !== 8'h07 ||
        a_if.bin !== 7'd7 || a_count !== 7'd2) begin
      failures++;
      $display("FAIL rej_ball: got v=%b bcd=%h bin=%0d cnt=%0d want 1 07 7 2",
               a_if.valid, a_if.bcd, a_if.bin, a_count);
    end
    a_if.ready = 1'b1;
    tick();
    a_if.ready = 1'b0;
  endtask

  task automatic test_fallback;
    int steps;
    bit got;
    steps = 0;
    got = 1'b0;
    a_prng = 8'h42;
    a_draw_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      a_draw_req = 1'b0;
      if (a_step === 1'b1) steps++;
      if (a_if.valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL fb_timeout: got no ball in 40 cycles want ball");
    end
    checks++;
    if (steps != 16) begin
      failures++;
      $display("FAIL fb_steps: got %0d want 16", steps);
    end
    checks++;
    if (a_if.bin !== 7'd1 || a_if.bcd !== 8'h01 ||
        a_if.fallback !== 1'b1) begin
      failures++;
      $display("FAIL fb_ball: got bin=%0d bcd=%h fb=%b want 1 01 1",
               a_if.bin, a_if.bcd, a_if.fallback);
    end
    a_if.ready = 1'b1;
    tick();
    a_if.ready = 1'b0;
  endtask

  task automatic test_stall;
    int bad;
    bad = 0;
    a_prng = 8'h75;
    a_draw_req = 1'b1;
    tick();
    a_draw_req = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      a_draw_req = i[0];
      a_prng = 8'h33;
      if (a_if.valid !== 1'b1 || a_if.bcd !== 8'h75 ||
          a_if.bin !== 7'd75 || a_step !== 1'b0 ||
          a_count !== 7'd4) bad++;
      tick();
    end
    a_draw_req = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall: got %0d unstable cycles want 0", bad);
    end
    a_if.ready = 1'b1;
    tick();
    a_if.ready = 1'b0;
    checks++;
    if (a_if.valid !== 1'b0 || a_count !== 7'd4) begin
      failures++;
      $display("FAIL stall_hs: got v=%b cnt=%0d want 0 4",
               a_if.valid, a_count);
    end
  endtask

  task automatic test_garbage;
    a_prng = 8'h4A;
    a_draw_req = 1'b1;
    tick();
    a_draw_req = 1'b0;
    tick();
    a_prng = 8'h76;
    tick();
    a_prng = 8'h11;
    checks++;
    if (a_step !== 1'b1 || a_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL garbage_rej: got step=%b v=%b want 1 0",
               a_step, a_if.valid);
    end
    tick();
    checks++;
    if (a_if.valid !== 1'b1 || a_if.bin !== 7'd11 ||
        a_if.bcd !== 8'h11 || a_count !== 7'd5) begin
      failures++;
      $display("FAIL garbage_ball: got v=%b bin=%0d bcd=%h cnt=%0d want 1 11 11 5",
               a_if.valid, a_if.bin, a_if.bcd, a_count);
    end
    a_if.ready = 1'b1;
    tick();
    a_if.ready = 1'b0;
  endtask

  task automatic b_draw(input logic [7:0] num);
    b_prng = num;
    b_draw_req = 1'b1;
    tick();
    b_draw_req = 1'b0;
    tick();
    b_if.ready = 1'b1;
    tick();
    b_if.ready = 1'b0;
  endtask

  task automatic test_small_game;
    b_draw(8'h01);
    b_draw(8'h02);
    checks++;
    if (b_all !== 1'b0 || b_count !== 7'd2) begin
      failures++;
      $display("FAIL small_two: got all=%b cnt=%0d want 0 2",
               b_all, b_count);
    end
    b_draw(8'h03);
    checks++;
    if (b_all !== 1'b1 || b_count !== 7'd3 ||
        b_busy !== 1'b0) begin
      failures++;
      $display("FAIL small_done: got all=%b cnt=%0d busy=%b want 1 3 0",
               b_all, b_count, b_busy);
    end
    b_draw_req = 1'b1;
    tick();
    b_draw_req = 1'b0;
    tick();
    checks++;
    if (b_all !== 1'b1 || b_step !== 1'b0 ||
        b_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL small_ignore: got all=%b step=%b v=%b want 1 0 0",
               b_all, b_step, b_if.valid);
    end
    b_new_game = 1'b1;
    tick();
    b_new_game = 1'b0;
    checks++;
    if (b_all !== 1'b0 || b_count !== 7'd0) begin
      failures++;
      $display("FAIL small_newgame: got all=%b cnt=%0d want 0 0",
               b_all, b_count);
    end
    b_draw(8'h01);
    b_prng = 8'h00;
    b_draw_req = 1'b1;
    tick();
    b_draw_req = 1'b0;
    checks++;
    if (b_busy !== 1'b1 || b_count !== 7'd1) begin
      failures++;
      $display("FAIL small_search: got busy=%b cnt=%0d want 1 1",
               b_busy, b_count);
    end
    b_new_game = 1'b1;
    tick();
    b_new_game = 1'b0;
    checks++;
    if (b_busy !== 1'b0 || b_count !== 7'd0 ||
        b_step !== 1'b0) begin
      failures++;
      $display("FAIL small_abort: got busy=%b cnt=%0d step=%b want 0 0 0",
               b_busy, b_count, b_step);
    end
    b_prng = 8'h01;
    b_draw_req = 1'b1;
    tick();
    b_draw_req = 1'b0;
    tick();
    checks++;
    if (b_if.valid !== 1'b1 || b_if.bin !== 7'd1 ||
        b_if.fallback !== 1'b0) begin
      failures++;
      $display("FAIL small_clear: got v=%b bin=%0d fb=%b want 1 1 0",
               b_if.valid, b_if.bin, b_if.fallback);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    a_new_game = 1'b0;
    a_draw_req = 1'b0;
    a_prng = 8'h00;
    a_if.ready = 1'b0;
    b_new_game = 1'b0;
    b_draw_req = 1'b0;
    b_prng = 8'h00;
    b_if.ready = 1'b0;
    test_reset();
    test_first_draw();
    test_rejects();
    test_fallback();
    test_stall();
    test_garbage();
    test_small_game();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
